// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source tags and FIFO entry layouts
// for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LS  = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] new_pc;
    logic [ROB_WIDTH-1:0]  rob_id;
  } alu_entry_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [ROB_WIDTH-1:0]  rob_id;
  } ls_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer/consumer bundle around the CDB arbiter:
// ALU and LS result channels in, one broadcast port out.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                  rdy_in;
  logic                  refresh_rob_cdb_in;
  logic                  rdy_a_in;
  logic [DATA_WIDTH-1:0] result_a_in;
  logic [ADDR_WIDTH-1:0] new_pc_a_in;
  logic [ROB_WIDTH-1:0]  rob_id_a_in;
  logic                  a_full_out;
  logic                  rdy_ls_in;
  logic [DATA_WIDTH-1:0] result_ls_in;
  logic [ROB_WIDTH-1:0]  rob_id_ls_in;
  logic                  ls_full_out;
  logic                  rdy_cdb_out;
  logic [DATA_WIDTH-1:0] result_cdb_out;
  logic [ADDR_WIDTH-1:0] new_pc_cdb_out;
  logic [ROB_WIDTH-1:0]  rob_id_cdb_out;
  logic                  src_cdb_out;
  logic                  overflow_out;

  modport master (
    output rdy_in, refresh_rob_cdb_in,
    output rdy_a_in, result_a_in,
    output new_pc_a_in, rob_id_a_in,
    output rdy_ls_in, result_ls_in,
    output rob_id_ls_in,
    input  a_full_out, ls_full_out,
    input  rdy_cdb_out, result_cdb_out,
    input  new_pc_cdb_out, rob_id_cdb_out,
    input  src_cdb_out, overflow_out
  );

  modport slave (
    input  rdy_in, refresh_rob_cdb_in,
    input  rdy_a_in, result_a_in,
    input  new_pc_a_in, rob_id_a_in,
    input  rdy_ls_in, result_ls_in,
    input  rob_id_ls_in,
    output a_full_out, ls_full_out,
    output rdy_cdb_out, result_cdb_out,
    output new_pc_cdb_out, rob_id_cdb_out,
    output src_cdb_out, overflow_out
  );

endinterface

// File: rtl/cdb_fifo.sv
// Circular-buffer FIFO holding results that lost
// CDB arbitration; clear empties it in one cycle.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [PW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Full blocks a push even when a pop frees a slot
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin merge of ALU and LS results onto one
// registered CDB, with per-source overflow FIFOs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = $clog2(FIFO_DEPTH)
) (
  input logic           clk_in,
  input logic           rst_in,
  cdb_arbiter_if.slave  bus
);

  alu_entry_t a_in, a_head, a_cand;
  ls_entry_t  ls_in, ls_head, ls_cand;
  logic a_empty, a_full, ls_empty, ls_full;
  logic [FIFO_WIDTH:0] a_cnt, ls_cnt;

  logic en, flush, act;
  logic a_cv, ls_cv, gnt_a, gnt_ls;
  logic a_req, ls_req;
  logic a_push, ls_push, a_pop, ls_pop;
  logic a_ovf, ls_ovf;

  logic                  prio_q, prio_d;
  logic                  rdy_q, rdy_d;
  logic                  src_q, src_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ROB_WIDTH-1:0]  rob_q, rob_d;

  assign en    = bus.rdy_in;
  assign flush = en & bus.refresh_rob_cdb_in;
  assign act   = en & ~flush;

  assign a_in  = '{result: bus.result_a_in,
                   new_pc: bus.new_pc_a_in,
                   rob_id: bus.rob_id_a_in};
  assign ls_in = '{result: bus.result_ls_in,
                   rob_id: bus.rob_id_ls_in};

  // Bypass only from an empty FIFO keeps per-source order
  assign a_cand  = a_empty  ? a_in  : a_head;
  assign ls_cand = ls_empty ? ls_in : ls_head;
  assign a_cv    = ~a_empty  | bus.rdy_a_in;
  assign ls_cv   = ~ls_empty | bus.rdy_ls_in;

  assign gnt_a  = a_cv & (~ls_cv | prio_q == CDB_SRC_ALU);
  assign gnt_ls = ls_cv & ~gnt_a;

  assign a_req  = act & bus.rdy_a_in & ~(gnt_a & a_empty);
  assign ls_req = act & bus.rdy_ls_in & ~(gnt_ls & ls_empty);
  assign a_push  = a_req & ~a_full;
  assign ls_push = ls_req & ~ls_full;
  assign a_ovf   = a_req & a_full;
  assign ls_ovf  = ls_req & ls_full;
  assign a_pop   = act & gnt_a & ~a_empty;
  assign ls_pop  = act & gnt_ls & ~ls_empty;

  cdb_fifo #(
    .W($bits(alu_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .PW(FIFO_WIDTH)
  ) u_a_fifo (
    .clk_i(clk_in), .rst_i(rst_in),
    .push_i(a_push), .pop_i(a_pop),
    .clear_i(flush), .data_i(a_in),
    .head_o(a_head), .empty_o(a_empty),
    .full_o(a_full), .count_o(a_cnt)
  );

  cdb_fifo #(
    .W($bits(ls_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .PW(FIFO_WIDTH)
  ) u_ls_fifo (
    .clk_i(clk_in), .rst_i(rst_in),
    .push_i(ls_push), .pop_i(ls_pop),
    .clear_i(flush), .data_i(ls_in),
    .head_o(ls_head), .empty_o(ls_empty),
    .full_o(ls_full), .count_o(ls_cnt)
  );

  always_comb begin
    prio_d = prio_q;
    rdy_d  = rdy_q;
    src_d  = src_q;
    res_d  = res_q;
    pc_d   = pc_q;
    rob_d  = rob_q;
    ovf_d  = ovf_q | a_ovf | ls_ovf;
    if (flush) begin
      prio_d = CDB_SRC_ALU;
      rdy_d  = 1'b0;
    end else if (en) begin
      rdy_d = gnt_a | gnt_ls;
      if (a_cv && ls_cv)
        prio_d = gnt_a ? CDB_SRC_LS : CDB_SRC_ALU;
      unique case (1'b1)
        gnt_a: begin
          src_d = CDB_SRC_ALU;
          res_d = a_cand.result;
          pc_d  = a_cand.new_pc;
          rob_d = a_cand.rob_id;
        end
        gnt_ls: begin
          src_d = CDB_SRC_LS;
          res_d = ls_cand.result;
          pc_d  = '0;
          rob_d = ls_cand.rob_id;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prio_q <= CDB_SRC_ALU;
      rdy_q  <= 1'b0;
      src_q  <= 1'b0;
      res_q  <= '0;
      pc_q   <= '0;
      rob_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rdy_q  <= rdy_d;
      src_q  <= src_d;
      res_q  <= res_d;
      pc_q   <= pc_d;
      rob_q  <= rob_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.a_full_out     = (a_cnt == (FIFO_WIDTH+1)'(FIFO_DEPTH));
  assign bus.ls_full_out    = (ls_cnt == (FIFO_WIDTH+1)'(FIFO_DEPTH));
  assign bus.rdy_cdb_out    = rdy_q;
  assign bus.src_cdb_out    = src_q;
  assign bus.result_cdb_out = res_q;
  assign bus.new_pc_cdb_out = pc_q;
  assign bus.rob_id_cdb_out = rob_q;
  assign bus.overflow_out   = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants, FIFOs,
// overflow, flush, stall and asynchronous reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [69:0] got, want;

  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  function automatic logic [69:0] obs();
    return {bus.rdy_cdb_out, bus.src_cdb_out,
            bus.rob_id_cdb_out, bus.result_cdb_out,
            bus.new_pc_cdb_out};
  endfunction

  function automatic logic [7:0] flags();
    return {bus.rdy_cdb_out, bus.src_cdb_out,
            bus.overflow_out, bus.a_full_out,
            bus.ls_full_out, 3'b000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input int rob,
                         input int res, input int pc);
    bus.rdy_a_in    = v;
    bus.rob_id_a_in = ROB_WIDTH'(rob);
    bus.result_a_in = DATA_WIDTH'(res);
    bus.new_pc_a_in = ADDR_WIDTH'(pc);
  endtask

  task automatic drive_ls(input logic v, input int rob,
                          input int res);
    bus.rdy_ls_in    = v;
    bus.rob_id_ls_in = ROB_WIDTH'(rob);
    bus.result_ls_in = DATA_WIDTH'(res);
  endtask

  task automatic idle();
    bus.rdy_a_in  = 1'b0;
    bus.rdy_ls_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++;
    if ((obs() | {62'd0, flags()}) !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h/%b want 0",
               obs(), flags());
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: rdy got %b want 0",
               bus.rdy_cdb_out);
    end
  endtask

  task automatic test_single();
    drive_a(1, 3, 'h12, 'h100);
    step();
    idle();
    got  = obs();
    want = {1'b1, 1'b0, 4'd3, 32'h12, 32'h100};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL single_bcast: got %h want %h",
               got, want);
    end
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b0) begin
      n_bad++;
      $display("FAIL single_once: rdy got %b want 0",
               bus.rdy_cdb_out);
    end
  endtask

  task automatic test_collision();
    do_reset();
    drive_a(1, 1, 'h11, 'h200);
    drive_ls(1, 2, 'h22);
    step();
    idle();
    got  = obs();
    want = {1'b1, 1'b0, 4'd1, 32'h11, 32'h200};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL coll1_alu: got %h want %h", got, want);
    end
    step();
    got  = obs();
    want = {1'b1, 1'b1, 4'd2, 32'h22, 32'h0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL coll1_ls: got %h want %h", got, want);
    end
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b0) begin
      n_bad++;
      $display("FAIL coll1_done: rdy got %b want 0",
               bus.rdy_cdb_out);
    end
    drive_a(1, 5, 'h55, 'h300);
    drive_ls(1, 6, 'h66);
    step();
    idle();
    got  = obs();
    want = {1'b1, 1'b1, 4'd6, 32'h66, 32'h0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL coll2_ls: got %h want %h", got, want);
    end
    step();
    got  = obs();
    want = {1'b1, 1'b0, 4'd5, 32'h55, 32'h300};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL coll2_alu: got %h want %h", got, want);
    end
  endtask

  // ALU i: rob i, 0x100+i, pc 0x1000+4i; LS i: rob 8+i, 0x200+i
  task automatic test_saturate();
    int i;
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      idle();
      if (e <= 9)
        drive_a(1, e-1, 'h100+e-1, 'h1000+4*(e-1));
      if (e <= 7)
        drive_ls(1, 8+e-1, 'h200+e-1);
      step();
      idle();
      if (e % 2 == 1) begin
        i = (e-1)/2;
        want = {1'b1, 1'b0, 4'(i), 32'('h100+i),
                32'('h1000+4*i)};
      end else begin
        i = e/2-1;
        want = {1'b1, 1'b1, 4'(8+i), 32'('h200+i), 32'h0};
      end
      got = obs();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL sat_grant e%0d: got %h want %h",
                 e, got, want);
      end
      if (e >= 7 && e <= 9) begin
        n_cmp++;
        if (flags() !== {2'b11,
              (e == 9), (e == 8), (e == 7), 3'b000}
            && flags() !== {1'b1, (e % 2 == 0),
              (e == 9), (e == 8), (e == 7), 3'b000}) begin
          n_bad++;
          $display("FAIL sat_flags e%0d: got %b", e, flags());
        end
      end
    end
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_drained: rdy got %b want 0",
               bus.rdy_cdb_out);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive_a(1, k, 'h300+k, 'h600+4*k);
      drive_ls(1, 8+k, 'h400+k);
      step();
    end
    bus.refresh_rob_cdb_in = 1'b1;
    drive_a(1, 7, 'h377, 'h6ff);
    drive_ls(1, 15, 'h477);
    step();
    bus.refresh_rob_cdb_in = 1'b0;
    idle();
    n_cmp++;
    if (flags() !== 8'b00100000) begin
      n_bad++;
      $display("FAIL flush_flags: got %b want 00100000",
               flags());
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.rdy_cdb_out !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_stale %0d: rdy got %b want 0",
                 k, bus.rdy_cdb_out);
      end
    end
    drive_a(1, 1, 'h31, 'h500);
    drive_ls(1, 2, 'h42);
    step();
    idle();
    got  = obs();
    want = {1'b1, 1'b0, 4'd1, 32'h31, 32'h500};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL flush_prio: got %h want %h", got, want);
    end
    step();
    got  = obs();
    want = {1'b1, 1'b1, 4'd2, 32'h42, 32'h0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL flush_ls: got %h want %h", got, want);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_a(1, 1, 'h71, 'h700);
    drive_ls(1, 9, 'h91);
    step();
    got  = obs();
    want = {1'b1, 1'b0, 4'd1, 32'h71, 32'h700};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL stall_pre: got %h want %h", got, want);
    end
    drive_a(1, 2, 'h72, 'h704);
    drive_ls(1, 10, 'h92);
    step();
    idle();
    bus.rdy_in = 1'b0;
    want = {1'b1, 1'b1, 4'd9, 32'h91, 32'h0};
    for (int k = 0; k < 6; k++) begin
      got = obs();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL stall_hold %0d: got %h want %h",
                 k, got, want);
      end
      if (k < 5) step();
    end
    bus.rdy_in = 1'b1;
    step();
    got  = obs();
    want = {1'b1, 1'b0, 4'd2, 32'h72, 32'h704};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL stall_r1: got %h want %h", got, want);
    end
    step();
    got  = obs();
    want = {1'b1, 1'b1, 4'd10, 32'h92, 32'h0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL stall_r2: got %h want %h", got, want);
    end
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_end: rdy got %b want 0",
               bus.rdy_cdb_out);
    end
  endtask

  task automatic test_async_reset();
    drive_a(1, 3, 'h81, 'h800);
    drive_ls(1, 11, 'ha1);
    step();
    drive_a(1, 4, 'h82, 'h804);
    drive_ls(1, 12, 'ha2);
    step();
    n_cmp++;
    if (bus.rdy_cdb_out !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: rdy got %b want 1",
               bus.rdy_cdb_out);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ((obs() | {62'd0, flags()}) !== '0) begin
      n_bad++;
      $display("FAIL arst_now: got %h/%b want 0",
               obs(), flags());
    end
    idle();
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (bus.rdy_cdb_out !== 1'b0) begin
        n_bad++;
        $display("FAIL arst_empty %0d: rdy got %b want 0",
                 k, bus.rdy_cdb_out);
      end
    end
    drive_a(1, 6, 'h99, 'h900);
    step();
    idle();
    got  = obs();
    want = {1'b1, 1'b0, 4'd6, 32'h99, 32'h900};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL arst_after: got %h want %h", got, want);
    end
  endtask

  initial begin
    bus.rdy_in             = 1'b1;
    bus.refresh_rob_cdb_in = 1'b0;
    drive_a(0, 0, 0, 0);
    drive_ls(0, 0, 0);
    test_reset();
    test_single();
    test_collision();
    test_saturate();
    test_flush();
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Merges the ALU and load/store result channels onto one registered common data bus (CDB). RS, LSBuffer and ROB then each snoop a single broadcast port instead of two. The block sits between the ALU/LSCtrl producers and the CDB consumers. It buffers results that lose arbitration in per-source FIFOs, grants round-robin, and discards everything on a ROB refresh (mispredict flush).

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per source FIFO; power of two, ≥ 2.
- `FIFO_WIDTH`, default log2(`FIFO_DEPTH`): pointer width.

Ports:
- `clk_in` in 1: system clock; only clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable; low freezes all state.
- `refresh_rob_cdb_in` in 1: ROB flush.
- `rdy_a_in` in 1: ALU result valid.
- `result_a_in` in `DATA_WIDTH`: ALU result.
- `new_pc_a_in` in `ADDR_WIDTH`: ALU branch target.
- `rob_id_a_in` in `ROB_WIDTH`: ALU ROB tag.
- `a_full_out` out 1: ALU FIFO full; ALU must hold off.
- `rdy_ls_in` in 1: LS result valid.
- `result_ls_in` in `DATA_WIDTH`: load data.
- `rob_id_ls_in` in `ROB_WIDTH`: LS ROB tag.
- `ls_full_out` out 1: LS FIFO full.
- `rdy_cdb_out` out 1: broadcast valid, one cycle per result.
- `result_cdb_out` out `DATA_WIDTH`: broadcast result.
- `new_pc_cdb_out` out `ADDR_WIDTH`: branch target; 0 for LS results.
- `rob_id_cdb_out` out `ROB_WIDTH`: broadcast tag.
- `src_cdb_out` out 1: 0 = ALU, 1 = LS.
- `overflow_out` out 1: sticky; an input arrived while its FIFO was full.

## Operation
- Per-source candidate each cycle:
  - If that source's FIFO is non-empty, the candidate is the FIFO head.
  - Otherwise the candidate is the valid incoming entry (bypass).
  - Bypass only when the FIFO is empty, so per-source order is preserved.
- Grant rule:
  - If exactly one candidate exists, it is granted.
  - If both exist, `prio` picks the winner, then `prio` flips to the loser.
  - `prio` is unchanged when at most one candidate exists.
- Granted entry is registered onto the CDB outputs. If it was a FIFO head, that entry is popped.
- Handling of an incoming entry that is not bypass-granted:
  - It is pushed into its FIFO if the FIFO is not full.
  - If the FIFO is full, the entry is dropped and `overflow_out` sets.
- Push and pop on the same FIFO in one cycle is legal; count is unchanged.
- `*_full_out` = (count == `FIFO_DEPTH`). It is derived from state only, with no input dependence. Full blocks a push even if a pop happens the same cycle.
- Flush (`refresh_rob_cdb_in` high with `rdy_in` high):
  - Both FIFOs are emptied (pointers and counts to 0).
  - Same-cycle inputs are dropped.
  - `rdy_cdb_out` is 0 next cycle.
  - `prio` resets to ALU.
  - `overflow_out` is kept.
- `rdy_in` low: no push, no pop, and `prio` is held. Outputs hold their values, including `rdy_cdb_out`. Producers hold their values too, since the codebase pauses globally.
- Reset (asynchronous, any time, including mid-burst):
  - FIFOs empty; `prio` = ALU (0).
  - All outputs 0: `rdy_cdb_out`, `result_cdb_out`, `new_pc_cdb_out`, `rob_id_cdb_out`, `src_cdb_out`, `overflow_out`, `a_full_out`, `ls_full_out`.

## Timing
- Latency from input valid at edge N to `rdy_cdb_out` high after edge N+1:
  - 1 cycle if uncontended.
  - 1 + k cycles if k entries are ahead in the same FIFO, plus interleaving with the other source.
- Throughput: one broadcast per cycle total.
- `rdy_cdb_out` is high for exactly one cycle per granted result while `rdy_in` is high. It is low on any cycle with no candidate.
- FIFO pointers wrap modulo `FIFO_DEPTH`; count is `FIFO_WIDTH`+1 bits wide.
- Flush takes priority over grant, push and pop in the same cycle. Reset takes priority over everything.

## Structure
- Widths come from the shared `define.vh`: `DATA_WIDTH`, `ADDR_WIDTH`, `ROB_WIDTH`.
- New shared constants go there too: `CDB_SRC_ALU` = 1'b0, `CDB_SRC_LS` = 1'b1.
- Sub-module `cdb_fifo`:
  - Parameterized width and depth.
  - Ports: push, pop, clear, head data, empty, full, count.
  - Instantiated twice: ALU entry = result + new_pc + rob_id; LS entry = result + rob_id.
- Top level holds the candidate mux, the `prio` register and the output registers.

## Test plan
- Single ALU result 0x12, rob_id 3, new_pc 0x100 → after 1 edge: `rdy_cdb_out`=1, `src`=0, result 0x12, rob_id 3, new_pc 0x100; low the following cycle.
- ALU (rob 1) and LS (rob 2) valid in the same cycle from reset → broadcasts rob 1 (ALU) then rob 2 (LS) on consecutive cycles; a second collision then grants LS first.
- ALU and LS both valid every cycle, `FIFO_DEPTH`=4 → grants alternate ALU/LS; `a_full_out` and `ls_full_out` assert once a FIFO count reaches 4; an input forced while full sets `overflow_out`.
- Refresh with 3 entries queued plus inputs valid that cycle → next cycle `rdy_cdb_out`=0, both FIFOs empty, no stale broadcast afterwards, `overflow_out` unchanged.
- `rdy_in` low for 5 cycles with a queue of 2 → outputs frozen, no pops; the remaining entries broadcast in order after `rdy_in` returns.
- Assert `rst_in` asynchronously between clock edges mid-burst → all outputs 0 immediately, without waiting for a clock edge; FIFOs empty after release.
